// File: rtl/timer_pkg.sv
// Shared constants for the cook-timer digit counters.
// Holds digit width, modulo-6 bounds and the preset saturation helper.
package timer_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] MOD6_MAX = 4'd5;
  localparam logic [DIGIT_W-1:0] MOD6_MIN = 4'd0;

  // Keypad presets above the digit's range clamp to its maximum.
  function automatic logic [DIGIT_W-1:0] mod6_saturate(input logic [DIGIT_W-1:0] value);
    return (value > MOD6_MAX) ? MOD6_MAX : value;
  endfunction

endpackage

// File: rtl/counter_mod_6.sv
// Tens-of-seconds digit of the cook timer: presettable modulo-6 down-counter with borrow.
// Optional `zero` port when COUNTER_MOD_6_ZERO_EN is defined.
module counter_mod_6
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               clearn,
  input  logic [DIGIT_W-1:0] data,
  input  logic               loadn,
  input  logic               EN,
  output logic [DIGIT_W-1:0] tens,
  output logic               tc
`ifdef COUNTER_MOD_6_ZERO_EN
  ,
  output logic               zero
`endif
);

  logic [DIGIT_W-1:0] tens_q;
  logic [DIGIT_W-1:0] tens_d;
  logic               at_min;

  assign at_min = (tens_q == MOD6_MIN);

  // Load beats count; the 0 -> 5 wrap keeps the digit inside 0..5.
  always_comb begin
    // NOTE: default assignment first so every path drives tens_d and no latch is inferred.
    tens_d = tens_q;
    if (!loadn) begin
      tens_d = mod6_saturate(data);
    end else if (EN) begin
      tens_d = at_min ? MOD6_MAX : tens_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clearn) begin
    // NOTE: non-blocking assignment for registered state avoids simulation races between flops.
    if (!clearn) begin
      tens_q <= MOD6_MIN;
    end else begin
      tens_q <= tens_d;
    end
  end

  assign tens = tens_q;
  assign tc   = EN & at_min;

`ifdef COUNTER_MOD_6_ZERO_EN
  assign zero = at_min;
`endif

endmodule

// File: tb/tb_counter_mod_6.sv
// Self-checking bench for counter_mod_6: directed table, corner sequences, random vs. model.
// Honours COUNTER_MOD_6_ZERO_EN when the design is built with the zero port.
module tb_counter_mod_6;

  logic       clk;
  logic       clearn;
  logic [3:0] data;
  logic       loadn;
  logic       EN;
  logic [3:0] tens;
  logic       tc;
`ifdef COUNTER_MOD_6_ZERO_EN
  logic       zero;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  counter_mod_6 dut (
    .clk    (clk),
    .clearn (clearn),
    .data   (data),
    .loadn  (loadn),
    .EN     (EN),
    .tens   (tens),
    .tc     (tc)
`ifdef COUNTER_MOD_6_ZERO_EN
    ,
    .zero   (zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       loadn;
    logic       en;
    logic [3:0] data;
    logic [3:0] exp_tens;
    logic       exp_tc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input int actual, input int expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_outputs(input string name, input int exp_tens);
    check({name, ".tens"}, int'(tens), exp_tens);
    check({name, ".tc"}, int'(tc), int'(EN && exp_tens == 0));
`ifdef COUNTER_MOD_6_ZERO_EN
    check({name, ".zero"}, int'(zero), int'(exp_tens == 0));
`endif
  endtask

  // Drive inputs, take one rising edge, leave outputs settled 1 ns after it.
  task automatic step(input logic ld_n, input logic en, input logic [3:0] d);
    loadn = ld_n;
    EN    = en;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  // Reference: digit value from the counting rules, in plain integer arithmetic.
  function automatic int model_next(input int cur, input bit ld_n, input bit en, input int d);
    if (!ld_n) return (d > 5) ? 5 : d;
    if (en)    return (cur + 5) % 6;
    return cur;
  endfunction

  initial begin
    int model;
    int tc_pulses;

    clearn = 1'b0;
    loadn  = 1'b1;
    EN     = 1'b0;
    data   = 4'd0;
    #12;
    check_outputs("reset_en0", 0);
    EN = 1'b1;
    #1;
    check_outputs("reset_en1", 0);
    EN = 1'b0;
    @(negedge clk);
    clearn = 1'b1;

    // Directed table, applied back-to-back from the cleared state.
    vecs.push_back('{1'b0, 1'b0, 4'd5,  4'd5, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd4, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd3, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd2,  4'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd7,  4'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  4'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd9,  4'd2, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 4'd0,  4'd2, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd3,  4'd3, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd9,  4'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd0,  4'd0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 4'd0,  4'd0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd15, 4'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'd6,  4'd5, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 4'd1,  4'd1, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 4'd0,  4'd0, 1'b1});

    foreach (vecs[i]) begin
      step(vecs[i].loadn, vecs[i].en, vecs[i].data);
      check($sformatf("vec%0d.tens", i), int'(tens), int'(vecs[i].exp_tens));
      check($sformatf("vec%0d.tc", i), int'(tc), int'(vecs[i].exp_tc));
    end

    // Async clear mid-count at 3: immediate zero, then one enabled edge gives 5.
    step(1'b0, 1'b0, 4'd3);
    check_outputs("pre_clear", 3);
    EN = 1'b1;
    loadn = 1'b1;
    #2;
    clearn = 1'b0;
    #1;
    check_outputs("async_clear", 0);
    @(posedge clk);
    #1;
    check_outputs("clear_held_over_edge", 0);
    clearn = 1'b1;
    step(1'b1, 1'b1, 4'd0);
    check_outputs("after_clear_release", 5);

    // Free run from 0 for 12 edges: two full 5..0 laps, borrow seen twice.
    step(1'b0, 1'b0, 4'd0);
    check_outputs("free_run_start", 0);
    tc_pulses = 0;
    model = 0;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 1'b1, 4'd0);
      model = model_next(model, 1'b1, 1'b1, 0);
      check_outputs($sformatf("free_run%0d", k), model);
      if (tc) tc_pulses++;
    end
    check("free_run_tc_pulses", tc_pulses, 2);

    // Random traffic against the reference model, with occasional async clears.
    for (int k = 0; k < 400; k++) begin
      logic ld_n, en;
      logic [3:0] d;
      ld_n = ($urandom_range(0, 7) != 0);
      en   = $urandom_range(0, 1) == 1;
      d    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 31) == 0) begin
        #2;
        clearn = 1'b0;
        #1;
        model = 0;
        check_outputs($sformatf("rand_clear%0d", k), model);
        clearn = 1'b1;
      end
      step(ld_n, en, d);
      model = model_next(model, ld_n, en, int'(d));
      check_outputs($sformatf("rand%0d", k), model);
      check($sformatf("rand%0d.bit3", k), int'(tens[3]), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/counter_mod_6.md
# counter_mod_6

Modulo-6 down-counter holding the tens-of-seconds digit (0–5) of the microwave cook timer. It is presettable from the keypad data path, decrements once per enabled clock, and wraps 0 → 5. It also provides a terminal-count borrow that enables the minutes stage. It sits between the seconds-units counter (which drives `EN`) and the minutes counter (driven by `tc`).

## Interface
- Parameters: none; constants come from the shared package.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `clearn`  in  1  reset; asynchronous, active-low; forces the count to 0.
- `data`  in  4  preset value (BCD) loaded when `loadn` = 0.
- `loadn`  in  1  synchronous load, active-low.
- `EN`  in  1  count enable, active-high (borrow from the units stage).
- `tens`  out  4  current count, 0–5, zero-extended to 4 bits.
- `tc`  out  1  terminal count / borrow: `EN` & (`tens` == 0).
- `zero`  out  1  `tens` == 0. Present only when `COUNTER_MOD_6_ZERO_EN` is defined.

## Operation
- Priority, highest first: `clearn` low → `loadn` low → `EN` high → hold.
- Clear: while `clearn` = 0, `tens` = 0 immediately, regardless of `clk`; all other inputs are ignored.
- Load: on a rising edge with `loadn` = 0, `tens` ← `data` if `data` ≤ 5, otherwise `tens` ← 5 (saturate). Load is independent of `EN`.
- Count: on a rising edge with `loadn` = 1 and `EN` = 1:
  - `tens` ← `tens` − 1.
  - If `tens` = 0, it wraps to 5.
- Hold: `EN` = 0 and `loadn` = 1 keeps `tens` unchanged.
- `tens` never leaves 0–5; bit 3 is always 0.
- `tc` and `zero` are combinational from the registered count and `EN`, with no extra state.

## Timing
- Reset values: `tens` = 0; `zero` = 1; `tc` = `EN`.
- Load and count latency: one clock. The new value is visible after the capturing edge.
- Clear is asynchronous on the falling edge of `clearn`. Release is synchronous in effect: the first state change after release happens on the next rising edge.
- Load and enable on the same edge: load wins and no decrement occurs that cycle.
- `tc` is high in the same cycle in which the 0 → 5 wrap occurs, so the downstream stage decrements on that same edge.
- Clear mid-count: the count is lost and the counter resumes from 0. With `EN` = 1 the next edge gives 5.

## Configuration
- Macro: `COUNTER_MOD_6_ZERO_EN`.
- Defined: the `zero` output port exists and equals (`tens` == 0).
- Undefined: no `zero` port. The parent derives zero detection from `tens`. `tc` behaviour is unchanged either way.

## Structure
- Shared package `timer_pkg` holds:
  - `DIGIT_W` = 4 (BCD digit width).
  - `MOD6_MAX` = 4'd5.
  - `MOD6_MIN` = 4'd0.
- No sub-module is needed. The block is a single `always` register with a combinational next-value select (clear/load-saturate/decrement-wrap/hold) plus the `tc`/`zero` assigns.

## Test plan
- Load then count: `clearn` = 1, `loadn` = 0, `data` = 5, one edge → `tens` = 5. Then `loadn` = 1, `EN` = 1 for 6 edges → 4, 3, 2, 1, 0, 5. `tc` = 1 only while `tens` = 0.
- Async clear mid-count: at `tens` = 3, pulse `clearn` = 0 between edges → `tens` = 0 immediately, `zero` = 1. Release, then one enabled edge → 5.
- Hold: `EN` = 0, `loadn` = 1 for 4 edges at `tens` = 2 → stays 2; `tc` = 0.
- Load priority and saturation:
  - `loadn` = 0, `EN` = 1, `data` = 3 → `tens` = 3, no decrement.
  - `data` = 9 → `tens` = 5.
  - `data` = 0 → `tens` = 0, `tc` = `EN`.
- Free run: `EN` = 1 for 12 edges from 0 → two full cycles 5…0; `tc` pulses exactly twice.
